// File: rtl/instr_fetch_mem.sv
// -----------------------------------------------------------------------------
// instr_fetch_mem
//   Instruction memory placed between the fetch stage (PC) and decode.
//   A fetch request is a byte address presented on a valid/ready port. The
//   matching response appears one cycle after the request is accepted and is
//   held in a single response register. That register is also what applies
//   back-pressure to the fetch stage. A separate load port writes program
//   words into the array. Program contents are supplied only through this
//   port; the array has no preload.
//
// Handshake rules (both ports):
//   A transfer happens on a rising clock edge where valid && ready are both 1.
//   A producer holds valid and its payload until the transfer happens.
//   ready may depend combinationally on the state of the consumer.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   1       fetch request present
//   req_ready  out  1       request accepted when req_valid && req_ready
//   req_addr   in   ADDR_W  byte address of the instruction
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       consumer takes response when rsp_valid && rsp_ready
//   rsp_instr  out  DATA_W  fetched instruction (NOP_INSTR on any fault)
//   rsp_fault  out  2       [0] misaligned, [1] word index >= DEPTH
//   ld_en      in   1       program-load write strobe
//   ld_idx     in   IDX_W   word index to write (ignored when >= DEPTH)
//   ld_data    in   DATA_W  word to write
//   fetch_cnt  out  16      accepted fetch requests, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module instr_fetch_mem #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter int                DEPTH     = 64,
   parameter int                IDX_W     = $clog2(DEPTH),
   parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_instr,
   output logic [1:0]        rsp_fault,
   input  logic              ld_en,
   input  logic [IDX_W-1:0]  ld_idx,
   input  logic [DATA_W-1:0] ld_data,
   output logic [15:0]       fetch_cnt
);

   // Range limits held at the width of the value each one is compared with.
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
   localparam logic [IDX_W:0]    DEPTH_I = (IDX_W + 1)'(DEPTH);

   // Instruction storage. It has no reset, so a program survives rst_n.
   logic [DATA_W-1:0] r_mem [0:DEPTH-1];

   // Response register and counter.
   logic              r_valid;
   logic [DATA_W-1:0] r_instr;
   logic [1:0]        r_fault;
   logic [15:0]       r_cnt;

   logic [ADDR_W-1:0] w_word_addr;
   logic              w_misalign;
   logic              w_out_of_range;
   logic [1:0]        w_fault;
   logic              w_req_ready;
   logic              w_accept;
   logic              w_ld_ok;
   logic [DATA_W-1:0] w_rd_word;

   // The range check uses the whole shifted address. Truncating the address
   // to IDX_W bits first would alias high addresses back into the array.
   assign w_word_addr    = req_addr >> 2;
   assign w_misalign     = |req_addr[1:0];
   assign w_out_of_range = (w_word_addr >= DEPTH_A);
   assign w_fault        = {w_out_of_range, w_misalign};

   // The response slot is free when it is empty, or when it is being drained
   // in this same cycle. Forcing 0 during reset stops a request from being
   // accepted while the response register is cleared.
   assign w_req_ready = rst_n && (!r_valid || rsp_ready);
   assign w_accept    = req_valid && w_req_ready;

   // The array is read only when the index is in range. If the index is out
   // of range, the mux below selects NOP_INSTR, so the array value is unused.
   assign w_rd_word = r_mem[w_word_addr[IDX_W-1:0]];

   // Matters only when DEPTH is not a power of two.
   assign w_ld_ok = ({1'b0, ld_idx} < DEPTH_I);

   // Program-load write port. It does not depend on the fetch handshake, so
   // a stalled response never blocks a write. On an index collision the read
   // above still sees the old word this cycle, which gives read-before-write.
   always_ff @(posedge clk) begin
      if (ld_en && w_ld_ok) begin
         r_mem[ld_idx] <= ld_data;
      end
   end

   // Response register. rsp_instr and rsp_fault change only when a request is
   // accepted. They stay stable through a stall and keep their values after
   // the response drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_instr <= NOP_INSTR;
         r_fault <= 2'b00;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_fault <= w_fault;
         r_instr <= (|w_fault) ? NOP_INSTR : w_rd_word;
      end else if (rsp_ready) begin
         r_valid <= 1'b0;
      end
   end

   // Counts every accepted request, including faulting ones. Saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 16'h0000;
      end else if (w_accept && (r_cnt != 16'hFFFF)) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   assign req_ready = w_req_ready;
   assign rsp_valid = r_valid;
   assign rsp_instr = r_instr;
   assign rsp_fault = r_fault;
   assign fetch_cnt = r_cnt;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_mem
//   Directed checks for instr_fetch_mem with DEPTH = 64 and NOP_INSTR = 0.
//   Each row of the vector table drives the inputs for one clock cycle.
//   Before the rising edge the bench checks req_ready. After the edge it
//   checks rsp_valid, rsp_instr, rsp_fault and fetch_cnt. Hand-written
//   sequences cover asynchronous reset in the middle of a stall and the
//   saturation of fetch_cnt.
// -----------------------------------------------------------------------------
module tb_instr_fetch_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic [1:0]  rsp_fault;
   logic        ld_en;
   logic [5:0]  ld_idx;
   logic [31:0] ld_data;
   logic [15:0] fetch_cnt;

   instr_fetch_mem #(
      .DATA_W    (32),
      .ADDR_W    (32),
      .DEPTH     (64),
      .NOP_INSTR (32'h00000000)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_instr (rsp_instr),
      .rsp_fault (rsp_fault),
      .ld_en     (ld_en),
      .ld_idx    (ld_idx),
      .ld_data   (ld_data),
      .fetch_cnt (fetch_cnt)
   );

   // Clock generator.
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One table row: inputs for one cycle and the outputs expected from it.
   typedef struct {
      logic        ld_en;
      logic [5:0]  ld_idx;
      logic [31:0] ld_data;
      logic        req_valid;
      logic [31:0] req_addr;
      logic        rsp_ready;
      logic        exp_rdy;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [1:0]  exp_fault;
      logic [15:0] exp_cnt;
   } vec_t;

   function automatic vec_t mk(input logic le, input logic [5:0] li, input logic [31:0] ld,
                               input logic rv, input logic [31:0] ra, input logic rr,
                               input logic er, input logic ev, input logic [31:0] ei,
                               input logic [1:0] ef, input logic [15:0] ec);
      vec_t v;
      v.ld_en = le;  v.ld_idx = li;  v.ld_data = ld;
      v.req_valid = rv;  v.req_addr = ra;  v.rsp_ready = rr;
      v.exp_rdy = er;  v.exp_valid = ev;  v.exp_instr = ei;
      v.exp_fault = ef;  v.exp_cnt = ec;
      return v;
   endfunction

   localparam int NV = 18;
   vec_t vecs [NV];

   initial begin
      //             ld  idx   data          rv  addr          rr  rdy val instr         flt    cnt
      // Load two words, then fetch them back to back.
      vecs[0]  = mk(1, 6'd0, 32'h20080020, 0, 32'h0,       1,  1,  0, 32'h00000000, 2'b00, 16'd0);
      vecs[1]  = mk(1, 6'd1, 32'h20090037, 0, 32'h0,       1,  1,  0, 32'h00000000, 2'b00, 16'd0);
      vecs[2]  = mk(0, 6'd0, 32'h0,        1, 32'h0,       1,  1,  1, 32'h20080020, 2'b00, 16'd1);
      vecs[3]  = mk(0, 6'd0, 32'h0,        1, 32'h4,       1,  1,  1, 32'h20090037, 2'b00, 16'd2);
      // Faults: misaligned, out of range, both. Counted and returning NOP.
      vecs[4]  = mk(0, 6'd0, 32'h0,        1, 32'h6,       1,  1,  1, 32'h00000000, 2'b01, 16'd3);
      vecs[5]  = mk(0, 6'd0, 32'h0,        1, 32'h100,     1,  1,  1, 32'h00000000, 2'b10, 16'd4);
      vecs[6]  = mk(0, 6'd0, 32'h0,        1, 32'h102,     1,  1,  1, 32'h00000000, 2'b11, 16'd5);
      // Drain: valid drops and the payload keeps its last value. Preload idx2.
      vecs[7]  = mk(1, 6'd2, 32'h11112222, 0, 32'h0,       1,  1,  0, 32'h00000000, 2'b11, 16'd5);
      // Stall: 0x0 accepted, then 0x4 held for three cycles with rsp_ready=0.
      vecs[8]  = mk(0, 6'd0, 32'h0,        1, 32'h0,       0,  1,  1, 32'h20080020, 2'b00, 16'd6);
      vecs[9]  = mk(0, 6'd0, 32'h0,        1, 32'h4,       0,  0,  1, 32'h20080020, 2'b00, 16'd6);
      vecs[10] = mk(0, 6'd0, 32'h0,        1, 32'h4,       0,  0,  1, 32'h20080020, 2'b00, 16'd6);
      vecs[11] = mk(0, 6'd0, 32'h0,        1, 32'h4,       0,  0,  1, 32'h20080020, 2'b00, 16'd6);
      vecs[12] = mk(0, 6'd0, 32'h0,        1, 32'h4,       1,  1,  1, 32'h20090037, 2'b00, 16'd7);
      // Collision: a write to idx2 in the same cycle as fetch 0x8 returns the old word.
      vecs[13] = mk(1, 6'd2, 32'hDEADBEEF, 1, 32'h8,       1,  1,  1, 32'h11112222, 2'b00, 16'd8);
      vecs[14] = mk(0, 6'd0, 32'h0,        1, 32'h8,       1,  1,  1, 32'hDEADBEEF, 2'b00, 16'd9);
      // A write during a stall completes and leaves the held response unchanged.
      vecs[15] = mk(1, 6'd3, 32'hCAFE0003, 0, 32'h0,       0,  0,  1, 32'hDEADBEEF, 2'b00, 16'd9);
      vecs[16] = mk(0, 6'd0, 32'h0,        1, 32'hC,       1,  1,  1, 32'hCAFE0003, 2'b00, 16'd10);
      vecs[17] = mk(0, 6'd0, 32'h0,        0, 32'h0,       1,  1,  0, 32'hCAFE0003, 2'b00, 16'd10);
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      rsp_ready = 1'b0;
      ld_en     = 1'b0;
      ld_idx    = '0;
      ld_data   = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset.rsp_instr", rsp_instr, 32'h0);
      chk("reset.rsp_fault", 32'(rsp_fault), 32'd0);
      chk("reset.fetch_cnt", 32'(fetch_cnt), 32'd0);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      #1;
      chk("reset.req_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         ld_en     = vecs[i].ld_en;
         ld_idx    = vecs[i].ld_idx;
         ld_data   = vecs[i].ld_data;
         req_valid = vecs[i].req_valid;
         req_addr  = vecs[i].req_addr;
         rsp_ready = vecs[i].rsp_ready;
         #1;
         chk($sformatf("v%0d.req_ready", i), 32'(req_ready), 32'(vecs[i].exp_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d.rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("v%0d.rsp_instr", i), rsp_instr, vecs[i].exp_instr);
         chk($sformatf("v%0d.rsp_fault", i), 32'(rsp_fault), 32'(vecs[i].exp_fault));
         chk($sformatf("v%0d.fetch_cnt", i), 32'(fetch_cnt), 32'(vecs[i].exp_cnt));
      end

      // Asynchronous reset asserted while a response is stalled.
      @(negedge clk);
      ld_en     = 1'b0;
      req_valid = 1'b1;
      req_addr  = 32'h4;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("stall.rsp_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("async_rst.req_ready", 32'(req_ready), 32'd0);
      chk("async_rst.rsp_instr", rsp_instr, 32'h0);
      chk("async_rst.fetch_cnt", 32'(fetch_cnt), 32'd0);

      // The memory keeps its contents through reset.
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst.idx0", rsp_instr, 32'h20080020);
      req_addr = 32'h8;
      @(posedge clk);
      #1;
      chk("post_rst.idx2", rsp_instr, 32'hDEADBEEF);
      req_addr = 32'hC;
      @(posedge clk);
      #1;
      chk("post_rst.idx3", rsp_instr, 32'hCAFE0003);
      chk("post_rst.valid", 32'(rsp_valid), 32'd1);
      chk("post_rst.fetch_cnt", 32'(fetch_cnt), 32'd3);

      // Back-to-back accepts up to and past saturation of fetch_cnt.
      repeat (65531) @(posedge clk);
      #1;
      chk("sat.cnt_fffe", 32'(fetch_cnt), 32'h0000FFFE);
      @(posedge clk);
      #1;
      chk("sat.cnt_ffff", 32'(fetch_cnt), 32'h0000FFFF);
      repeat (3) @(posedge clk);
      #1;
      chk("sat.cnt_hold", 32'(fetch_cnt), 32'h0000FFFF);
      chk("sat.req_ready", 32'(req_ready), 32'd1);
      chk("sat.rsp_instr", rsp_instr, 32'hCAFE0003);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
